// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
//
// Main sequencer for the 16-bit multi-cycle processor. This is a Moore FSM
// that steers the fetch/memory datapath (PC, IR, MDR, shared memory), the
// register file and the ALU. Every memory-touching state (FETCH, MEM_RD,
// MEM_WR) is held for MEM_WAIT extra cycles so the core can run on slow memory.
//
// Ports
//   CLK, RESET_N        clock (rising edge), asynchronous active-low reset
//   opcode              IR control field, sampled and latched in DECODE
//   alu_zero/negative   ALU flags (branch outcome is resolved by the PC logic)
//   PCWrite, IsBranch, BranchType, PCSource           PC update controls
//   IRWrite, IorD, MemWrite                           memory / IR controls
//   RegWrite, MemToReg, RegDst                        register file controls
//   ALUSrcA, ALUSrcB, ALUOp                           ALU operand/operation
//   halted, fault       core stopped in HALT / illegal opcode seen
//   state_dbg           current state encoding
//   retired             completed-instruction counter, wraps at 2^CNT_W
//
// state   | meaning
// --------+----------------------------------------------------------
// FETCH   | read instruction at PC, PC <= PC + 1 on final wait cycle
// DECODE  | latch opcode, precompute branch target, dispatch
// EXEC_R  | register-register ALU operation
// EXEC_I  | register-immediate ALU operation
// ADDR    | effective address for LW/SW
// MEM_RD  | data read at ALUOut
// MEM_WR  | data write at ALUOut, strobe on final wait cycle
// WB_ALU  | write ALUOut to register file
// WB_MEM  | write MDR to register file
// BRANCH  | compare operands, conditional PC update
// JUMP    | PC <= Imm
// HALT    | stopped until reset
// FAULT   | illegal opcode, stopped until reset

module multicycle_control_fsm #(
    parameter int MEM_WAIT = 0,
    parameter int CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [6:0]       opcode,
    input  logic             alu_zero,
    input  logic             alu_negative,
    output logic             PCWrite,
    output logic             IsBranch,
    output logic [1:0]       BranchType,
    output logic             IRWrite,
    output logic             IorD,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic             MemToReg,
    output logic             RegDst,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             halted,
    output logic             fault,
    output logic [3:0]       state_dbg,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_EXEC_I = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM_RD = 4'd5,
        S_MEM_WR = 4'd6,
        S_WB_ALU = 4'd7,
        S_WB_MEM = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_HALT   = 4'd11,
        S_FAULT  = 4'd12
    } state_t;

    localparam logic [6:0] OP_RALU = 7'h01;
    localparam logic [6:0] OP_IALU = 7'h02;
    localparam logic [6:0] OP_LW   = 7'h03;
    localparam logic [6:0] OP_SW   = 7'h04;
    localparam logic [6:0] OP_JUMP = 7'h0C;
    localparam logic [6:0] OP_HALT = 7'h7F;

    localparam logic [3:0] WAIT_MAX = 4'(MEM_WAIT);

    state_t     state;
    state_t     next_state;
    logic [3:0] wait_cnt;
    logic [3:0] wait_cnt_nxt;
    logic [6:0] opcode_q;
    logic       wait_done;
    logic       mem_state;
    logic       retire;

    // The flags feed the PC-update logic directly; the sequencer never branches on them.
    logic flags_unused;
    assign flags_unused = alu_zero ^ alu_negative;

    assign wait_done = (wait_cnt == WAIT_MAX);
    assign mem_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);

    // An instruction is complete on the edge that leaves its last state.
    assign retire = (state == S_WB_ALU) || (state == S_WB_MEM) ||
                    (state == S_BRANCH) || (state == S_JUMP)   ||
                    ((state == S_MEM_WR) && wait_done);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= S_FETCH;
            wait_cnt <= 4'd0;
            opcode_q <= 7'd0;
            retired  <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= wait_cnt_nxt;
            if (state == S_DECODE) begin
                opcode_q <= opcode;
            end
            if (retire) begin
                retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Counter restarts from zero whenever a state is (re)entered, so each
    // memory state sees 0..MEM_WAIT regardless of where it came from.
    always_comb begin
        wait_cnt_nxt = 4'd0;
        if ((next_state == state) && mem_state && !wait_done) begin
            wait_cnt_nxt = wait_cnt + 4'd1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH: begin
                if (wait_done) next_state = S_DECODE;
            end
            S_DECODE: begin
                // Dispatch uses the live IR field; later states use the latched copy.
                if (opcode == OP_RALU)                          next_state = S_EXEC_R;
                else if (opcode == OP_IALU)                     next_state = S_EXEC_I;
                else if ((opcode == OP_LW) || (opcode == OP_SW)) next_state = S_ADDR;
                else if (opcode[6:2] == 5'b00010)               next_state = S_BRANCH;
                else if (opcode == OP_JUMP)                     next_state = S_JUMP;
                else if (opcode == OP_HALT)                     next_state = S_HALT;
                else                                            next_state = S_FAULT;
            end
            S_EXEC_R, S_EXEC_I: next_state = S_WB_ALU;
            S_ADDR:   next_state = (opcode_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (wait_done) next_state = S_WB_MEM;
            end
            S_MEM_WR: begin
                if (wait_done) next_state = S_FETCH;
            end
            S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: next_state = S_FETCH;
            S_HALT:   next_state = S_HALT;
            S_FAULT:  next_state = S_FAULT;
            default:  next_state = S_FETCH;
        endcase
    end

    // Outputs are forced low while reset is held; otherwise the FETCH
    // decode would present ALUSrcB=1 during reset.
    always_comb begin
        PCWrite    = 1'b0;
        IsBranch   = 1'b0;
        BranchType = 2'd0;
        IRWrite    = 1'b0;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        MemToReg   = 1'b0;
        RegDst     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'd0;
        ALUOp      = 2'd0;
        PCSource   = 2'd0;
        halted     = 1'b0;
        fault      = 1'b0;
        if (RESET_N) begin
            case (state)
                S_FETCH: begin
                    ALUSrcB = 2'd1;
                    IRWrite = wait_done;
                    PCWrite = wait_done;
                end
                S_DECODE: begin
                    ALUSrcB = 2'd2;
                end
                S_EXEC_R: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'd2;
                end
                S_EXEC_I, S_ADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'd2;
                end
                S_MEM_RD: begin
                    IorD = 1'b1;
                end
                S_MEM_WR: begin
                    IorD     = 1'b1;
                    MemWrite = wait_done;
                end
                S_WB_ALU: begin
                    RegWrite = 1'b1;
                    RegDst   = (opcode_q == OP_RALU);
                end
                S_WB_MEM: begin
                    RegWrite = 1'b1;
                    MemToReg = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA    = 1'b1;
                    ALUOp      = 2'd1;
                    IsBranch   = 1'b1;
                    PCSource   = 2'd1;
                    BranchType = opcode_q[1:0];
                end
                S_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'd2;
                end
                S_HALT:  halted = 1'b1;
                S_FAULT: fault  = 1'b1;
                default: ;
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: three instances with MEM_WAIT = 0, 2, 3
// (CNT_W = 4 so retired wraps quickly). Each instruction is expanded into its
// expected per-cycle control words from the opcode rules, then compared
// cycle by cycle against the DUT under test.

module tb_multicycle_control_fsm;

    typedef struct packed {
        logic       pc_write;
        logic       is_branch;
        logic [1:0] branch_type;
        logic       ir_write;
        logic       iord;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       halted;
        logic       fault;
        logic [3:0] st;
    } ctrl_t;

    logic            clk = 1'b0;
    logic [2:0]      rst_n;
    logic [2:0][6:0] opc;
    logic            flag_z;
    logic            flag_n;
    logic [2:0][22:0] ctrl_obs;
    logic [2:0][3:0]  ret_obs;

    int    waits[3] = '{0, 2, 3};
    int    exp_ret[3];
    int    n_vec = 0;
    int    n_err = 0;
    ctrl_t exp_q[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int W = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
        logic       pcw, isb, irw, iord, mw, rw, m2r, rd, asa, hlt, flt;
        logic [1:0] bt, asb, aop, pcs;
        logic [3:0] st;
        logic [3:0] ret;

        multicycle_control_fsm #(.MEM_WAIT(W), .CNT_W(4)) u_dut (
            .CLK          (clk),
            .RESET_N      (rst_n[g]),
            .opcode       (opc[g]),
            .alu_zero     (flag_z),
            .alu_negative (flag_n),
            .PCWrite      (pcw),
            .IsBranch     (isb),
            .BranchType   (bt),
            .IRWrite      (irw),
            .IorD         (iord),
            .MemWrite     (mw),
            .RegWrite     (rw),
            .MemToReg     (m2r),
            .RegDst       (rd),
            .ALUSrcA      (asa),
            .ALUSrcB      (asb),
            .ALUOp        (aop),
            .PCSource     (pcs),
            .halted       (hlt),
            .fault        (flt),
            .state_dbg    (st),
            .retired      (ret)
        );

        assign ctrl_obs[g] = {pcw, isb, bt, irw, iord, mw, rw, m2r, rd, asa, asb, aop, pcs, hlt, flt, st};
        assign ret_obs[g]  = ret;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h, expected %h", tag, $time, obs, exp);
        end
    endtask

    // Expected per-cycle control words for one instruction, derived from the
    // opcode table and the per-state output rules.
    task automatic expand(input logic [6:0] op, input int w, output bit ret, output bit stick);
        ctrl_t c;
        exp_q.delete();
        ret   = 1'b1;
        stick = 1'b0;
        for (int i = 0; i <= w; i++) begin
            c = '0; c.st = 4'd0; c.alu_src_b = 2'd1;
            c.pc_write = (i == w); c.ir_write = (i == w);
            exp_q.push_back(c);
        end
        c = '0; c.st = 4'd1; c.alu_src_b = 2'd2;
        exp_q.push_back(c);
        if (op == 7'h01 || op == 7'h02) begin
            c = '0; c.alu_src_a = 1'b1;
            if (op == 7'h01) begin c.st = 4'd2; c.alu_op = 2'd2; end
            else             begin c.st = 4'd3; c.alu_src_b = 2'd2; end
            exp_q.push_back(c);
            c = '0; c.st = 4'd7; c.reg_write = 1'b1; c.reg_dst = (op == 7'h01);
            exp_q.push_back(c);
        end else if (op == 7'h03 || op == 7'h04) begin
            c = '0; c.st = 4'd4; c.alu_src_a = 1'b1; c.alu_src_b = 2'd2;
            exp_q.push_back(c);
            for (int i = 0; i <= w; i++) begin
                c = '0; c.iord = 1'b1;
                if (op == 7'h03) c.st = 4'd5;
                else begin c.st = 4'd6; c.mem_write = (i == w); end
                exp_q.push_back(c);
            end
            if (op == 7'h03) begin
                c = '0; c.st = 4'd8; c.reg_write = 1'b1; c.mem_to_reg = 1'b1;
                exp_q.push_back(c);
            end
        end else if (op >= 7'h08 && op <= 7'h0B) begin
            c = '0; c.st = 4'd9; c.alu_src_a = 1'b1; c.alu_op = 2'd1;
            c.is_branch = 1'b1; c.pc_source = 2'd1; c.branch_type = op[1:0];
            exp_q.push_back(c);
        end else if (op == 7'h0C) begin
            c = '0; c.st = 4'd10; c.pc_write = 1'b1; c.pc_source = 2'd2;
            exp_q.push_back(c);
        end else begin
            c = '0; ret = 1'b0; stick = 1'b1;
            if (op == 7'h7F) begin c.st = 4'd11; c.halted = 1'b1; end
            else             begin c.st = 4'd12; c.fault  = 1'b1; end
            exp_q.push_back(c);
        end
    endtask

    // Entered and left at posedge+1; leaves reset released.
    task automatic do_reset(input int k);
        rst_n[k] = 1'b0;
        #1;
        chk("rst_ctrl", 32'(ctrl_obs[k]), 32'd0);
        chk("rst_retired", 32'(ret_obs[k]), 32'd0);
        @(posedge clk); #1;
        chk("rst_hold_ctrl", 32'(ctrl_obs[k]), 32'd0);
        exp_ret[k] = 0;
        rst_n[k] = 1'b1;
    endtask

    task automatic run_instr(input int k, input logic [6:0] op, input int abort_at);
        bit    ret, stick;
        ctrl_t last;
        expand(op, waits[k], ret, stick);
        for (int i = 0; i < exp_q.size(); i++) begin
            opc[k] = (i <= waits[k] + 1) ? op : 7'($urandom);
            flag_z = 1'($urandom); flag_n = 1'($urandom);
            #1;
            chk("ctrl", 32'(ctrl_obs[k]), 32'(exp_q[i]));
            chk("retired", 32'(ret_obs[k]), 32'(exp_ret[k]));
            if (i == abort_at) begin
                #2 rst_n[k] = 1'b0;
                #1;
                chk("abort_ctrl", 32'(ctrl_obs[k]), 32'd0);
                chk("abort_retired", 32'(ret_obs[k]), 32'd0);
                @(posedge clk); #1;
                chk("abort_hold_ctrl", 32'(ctrl_obs[k]), 32'd0);
                exp_ret[k] = 0;
                rst_n[k] = 1'b1;
                return;
            end
            @(posedge clk); #1;
        end
        if (ret) exp_ret[k] = (exp_ret[k] + 1) % 16;
        if (stick) begin
            last = exp_q[exp_q.size() - 1];
            for (int i = 0; i < 10; i++) begin
                opc[k] = 7'($urandom);
                #1;
                chk("stuck_ctrl", 32'(ctrl_obs[k]), 32'(last));
                chk("stuck_retired", 32'(ret_obs[k]), 32'(exp_ret[k]));
                @(posedge clk); #1;
            end
            do_reset(k);
        end
    endtask

    function automatic logic [6:0] rand_op();
        case ($urandom_range(0, 9))
            0, 8:    return 7'h01;
            1:       return 7'h02;
            2:       return 7'h03;
            3:       return 7'h04;
            4, 5:    return 7'(8 + $urandom_range(0, 3));
            6:       return 7'h0C;
            7:       return 7'($urandom);
            default: return 7'h02;
        endcase
    endfunction

    initial begin
        rst_n  = 3'b000;
        opc    = '0;
        flag_z = 1'b0;
        flag_n = 1'b0;
        exp_ret = '{0, 0, 0};
        @(posedge clk); #1;

        do_reset(0);
        run_instr(0, 7'h01, -1);
        run_instr(0, 7'h03, -1);
        run_instr(0, 7'h09, -1);
        run_instr(0, 7'h0C, -1);
        run_instr(0, 7'h02, -1);
        run_instr(0, 7'h04, -1);
        for (int n = 0; n < 30; n++) run_instr(0, rand_op(), -1);
        run_instr(0, 7'h55, -1);
        run_instr(0, 7'h7F, -1);

        do_reset(1);
        run_instr(1, 7'h04, -1);
        run_instr(1, 7'h0A, -1);
        run_instr(1, 7'h03, -1);
        for (int n = 0; n < 25; n++) run_instr(1, rand_op(), -1);
        run_instr(1, 7'h7F, -1);

        do_reset(2);
        // Second MEM_WR cycle of SW: FETCH x4, DECODE, ADDR, then MEM_WR from index 6.
        run_instr(2, 7'h04, 7);
        run_instr(2, 7'h04, -1);
        run_instr(2, 7'h03, -1);
        run_instr(2, 7'h0B, -1);
        for (int n = 0; n < 20; n++) run_instr(2, rand_op(), -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
